div_controller: RTL and testbench

DIV_CONTROLLER -- requirements
Module: div_controller

---
 rtl/div_controller.sv | 186 ++++++++++++++++++
 tb/tb_div_controller.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_controller.sv
// div_controller
//
// Sequences a multi-cycle divider for the EX stage: accepts a DIV/DIVU request, holds the
// pipeline while the divider runs, writes {remainder, quotient} to HI/LO, and recovers from
// pipeline flushes and from a divider that never answers (watchdog).
//
// Ports
//   clk, rst                       clock (rising edge), asynchronous active-high reset
//   ex_div_req_i, ex_op_i          EX stage divide request and its ALU control code
//   ex_opdata1_i, ex_opdata2_i     dividend / divisor
//   flush_i                        kills the instruction currently in EX
//   stall_o                        freeze EX and earlier stages (combinational)
//   div_start_o                    divider start (registered)
//   div_annul_o                    divider annul (combinational, only in RUN)
//   div_op_o, div_opdata*_o        latched copy of the accepted request
//   div_ready_i, div_result_i      divider completion and {remainder, quotient}
//   hilo_we_o, hi_o, lo_o          HI/LO write port
//   err_o                          one-cycle watchdog timeout pulse
module div_controller #(
    parameter int unsigned TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_req_i,
    input  logic [4:0]  ex_op_i,
    input  logic [31:0] ex_opdata1_i,
    input  logic [31:0] ex_opdata2_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic [4:0]  div_op_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        err_o
);

    // Counter holds the number of RUN cycles already elapsed; RUN may last TIMEOUT cycles.
    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StAbort
    } state_e;

    state_e            state_q, state_d;
    logic              start_q, start_d;
    logic [4:0]        op_q, op_d;
    logic [31:0]       opdata1_q, opdata1_d;
    logic [31:0]       opdata2_q, opdata2_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              abort_cnt_q, abort_cnt_d;
    logic              timeout_hit;

    assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        op_d        = op_q;
        opdata1_d   = opdata1_q;
        opdata2_d   = opdata2_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        err_d       = 1'b0;
        cnt_d       = cnt_q;
        abort_cnt_d = abort_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (ex_div_req_i && !flush_i) begin
                    op_d      = ex_op_i;
                    opdata1_d = ex_opdata1_i;
                    opdata2_d = ex_opdata2_i;
                    start_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                // Flush wins over a result arriving in the same cycle; a result arriving on
                // the last allowed cycle still completes normally.
                if (flush_i) begin
                    start_d     = 1'b0;
                    abort_cnt_d = 1'b0;
                    state_d     = StAbort;
                end else if (div_ready_i) begin
                    hi_d    = div_result_i[63:32];
                    lo_d    = div_result_i[31:0];
                    start_d = 1'b0;
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err_d       = 1'b1;
                    start_d     = 1'b0;
                    abort_cnt_d = 1'b0;
                    state_d     = StAbort;
                end
            end
            StDone: begin
                // The request still visible here is the instruction that just finished.
                state_d = StIdle;
            end
            StAbort: begin
                // Two cycles with start low let the divider drain back to its free state.
                start_d = 1'b0;
                if (abort_cnt_q) begin
                    state_d = StIdle;
                end else begin
                    abort_cnt_d = 1'b1;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            start_q     <= 1'b0;
            op_q        <= '0;
            opdata1_q   <= '0;
            opdata2_q   <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            abort_cnt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            op_q        <= op_d;
            opdata1_q   <= opdata1_d;
            opdata2_q   <= opdata2_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    // Combinational outputs are gated by rst so every output reads 0 while reset is held.
    always_comb begin
        stall_o     = 1'b0;
        div_annul_o = 1'b0;
        hilo_we_o   = 1'b0;
        unique case (state_q)
            StIdle:  stall_o = ex_div_req_i & ~flush_i;
            StRun: begin
                stall_o     = 1'b1;
                div_annul_o = flush_i | (timeout_hit & ~div_ready_i);
            end
            StDone:  hilo_we_o = ~flush_i;
            StAbort: stall_o = ex_div_req_i;
            default: stall_o = 1'b0;
        endcase
        if (rst) begin
            stall_o     = 1'b0;
            div_annul_o = 1'b0;
            hilo_we_o   = 1'b0;
        end
    end

    assign div_start_o   = start_q;
    assign div_op_o      = op_q;
    assign div_opdata1_o = opdata1_q;
    assign div_opdata2_o = opdata2_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_div_controller.sv
// Self-checking bench for div_controller: a behavioural divider answers div_start_o, expected
// HI/LO pairs are queued when a request is driven and compared on each hilo_we_o pulse.
module tb_div_controller;

    localparam int unsigned TIMEOUT      = 63;
    localparam logic [4:0]  DIV_CONTROL  = 5'b11010;
    localparam logic [4:0]  DIVU_CONTROL = 5'b11011;
    // Divider countdown loads; divider latency (first start cycle to ready cycle) is K + 2,
    // so request-to-DONE latency is K + 4.
    localparam int K_NORM = 8;
    localparam int K_ZERO = 1;
    localparam int K_SLOW = 20;
    localparam int LAT_NORM = K_NORM + 2 + 2;
    localparam int LAT_ZERO = K_ZERO + 2 + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div_req;
    logic [4:0]  ex_op;
    logic [31:0] ex_a, ex_b;
    logic        flush;
    logic        stall_o, div_start_o, div_annul_o, hilo_we_o, err_o;
    logic [4:0]  div_op_o;
    logic [31:0] div_opdata1_o, div_opdata2_o, hi_o, lo_o;
    logic        div_ready;
    logic [63:0] div_result;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int hilo_pulses = 0;
    logic [63:0] exp_q[$];

    div_controller #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_div_req_i  (ex_div_req),
        .ex_op_i       (ex_op),
        .ex_opdata1_i  (ex_a),
        .ex_opdata2_i  (ex_b),
        .flush_i       (flush),
        .stall_o       (stall_o),
        .div_start_o   (div_start_o),
        .div_annul_o   (div_annul_o),
        .div_op_o      (div_op_o),
        .div_opdata1_o (div_opdata1_o),
        .div_opdata2_o (div_opdata2_o),
        .div_ready_i   (div_ready),
        .div_result_i  (div_result),
        .hilo_we_o     (hilo_we_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] div_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        logic [31:0] uq, ur;
        if (b == 32'd0) return 64'd0;
        if (op == DIV_CONTROL) begin
            sa = a;
            sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    // Behavioural divider: starts on div_start_o, answers after a countdown, drops on annul.
    int   stub_k;
    logic stub_hang;
    logic stub_busy;
    int   stub_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_busy  <= 1'b0;
            stub_cnt   <= 0;
            div_ready  <= 1'b0;
            div_result <= 64'd0;
        end else begin
            div_ready <= 1'b0;
            if (!div_start_o || div_annul_o) begin
                stub_busy <= 1'b0;
            end else if (!stub_busy && !div_ready) begin
                stub_busy  <= 1'b1;
                stub_cnt   <= (div_opdata2_o == 32'd0) ? K_ZERO : stub_k;
                div_result <= div_model(div_op_o, div_opdata1_o, div_opdata2_o);
            end else if (stub_busy && !stub_hang) begin
                if (stub_cnt == 0) begin
                    div_ready <= 1'b1;
                    stub_busy <= 1'b0;
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    // Scoreboard: every HI/LO write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst) begin
            if (err_o) err_pulses++;
            if (hilo_we_o) begin
                hilo_pulses++;
                if (exp_q.size() == 0) begin
                    check_eq("hilo_unexpected", 64'(hilo_we_o), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("hi", 64'(hi_o), 64'(e[63:32]));
                    check_eq("lo", 64'(lo_o), 64'(e[31:0]));
                end
            end
        end
    end

    // Called just after a rising edge; returns at the falling edge of the DONE cycle.
    task automatic do_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input int exp_lat,
                          input string tag);
        int n;
        bit done;
        int bad_stall;
        ex_div_req = 1'b1;
        ex_op      = op;
        ex_a       = a;
        ex_b       = b;
        exp_q.push_back({hi, lo});
        @(negedge clk);
        check_eq({tag, "_stall_req"}, 64'(stall_o), 64'd1);
        n = 0;
        done = 1'b0;
        bad_stall = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            @(negedge clk);
            if (hilo_we_o) begin
                done = 1'b1;
                check_eq({tag, "_done_stall"}, 64'(stall_o), 64'd0);
            end else if (!stall_o) begin
                bad_stall++;
            end
        end
        check_eq({tag, "_done"}, 64'(done), 64'd1);
        check_eq({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check_eq({tag, "_stall_run"}, 64'(bad_stall), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctrl"}, 64'({stall_o, div_start_o, div_annul_o, hilo_we_o, err_o,
                                      div_op_o}), 64'd0);
        check_eq({tag, "_opdata"}, {div_opdata1_o, div_opdata2_o}, 64'd0);
        check_eq({tag, "_hilo"}, {hi_o, lo_o}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int annul_cycle;
        int err_cycle;
        int err_before;
        int hilo_before;
        bit abort_ok;
        bit run_ok;

        rst        = 1'b1;
        ex_div_req = 1'b0;
        ex_op      = 5'd0;
        ex_a       = 32'd0;
        ex_b       = 32'd0;
        flush      = 1'b0;
        stub_k     = K_NORM;
        stub_hang  = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back divides, including divide-by-zero with its shorter latency.
        do_div(DIV_CONTROL, 32'd100, 32'd7, 32'd2, 32'd14, LAT_NORM, "div_100_7");
        @(posedge clk); #1;
        do_div(DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, LAT_NORM,
               "div_m7_2");
        @(posedge clk); #1;
        do_div(DIVU_CONTROL, 32'd5, 32'd0, 32'd0, 32'd0, LAT_ZERO, "divu_5_0");
        @(posedge clk); #1;
        do_div(DIVU_CONTROL, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF, LAT_NORM,
               "divu_max_2");
        @(posedge clk); #1;
        ex_div_req = 1'b0;

        // HI/LO hold with no write pending.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("hold_hilo", {hi_o, lo_o}, {32'd1, 32'h7FFF_FFFF});
        check_eq("hold_ctrl", 64'({hilo_we_o, stall_o, div_start_o}), 64'd0);

        // Flush on the 10th RUN cycle.
        stub_k = K_SLOW;
        @(posedge clk); #1;
        ex_div_req = 1'b1;
        ex_op      = DIV_CONTROL;
        ex_a       = 32'd50;
        ex_b       = 32'd5;
        @(negedge clk);
        run_ok = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            ex_a = 32'hDEAD_BEEF;
            @(negedge clk);
            run_ok &= div_start_o & stall_o & ~div_annul_o & (div_opdata1_o == 32'd50) &
                      (div_opdata2_o == 32'd5) & (div_op_o == DIV_CONTROL);
        end
        check_eq("flush_run_hold", 64'(run_ok), 64'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_annul", 64'({div_annul_o, hilo_we_o}), 64'b10);
        @(posedge clk); #1;
        flush      = 1'b0;
        ex_div_req = 1'b0;
        stub_k     = K_NORM;
        @(negedge clk);
        check_eq("abort1", 64'({div_annul_o, div_start_o, stall_o}), 64'd0);
        @(posedge clk); #1;
        ex_div_req = 1'b1;
        ex_a       = 32'd9;
        ex_b       = 32'd3;
        @(negedge clk);
        check_eq("abort2_stall", 64'({stall_o, div_start_o}), 64'b10);
        @(posedge clk); #1;
        do_div(DIV_CONTROL, 32'd9, 32'd3, 32'd0, 32'd3, LAT_NORM, "div_9_3");
        @(posedge clk); #1;
        ex_div_req = 1'b0;

        // Watchdog: the divider never answers.
        @(posedge clk); #1;
        stub_hang   = 1'b1;
        err_before  = err_pulses;
        hilo_before = hilo_pulses;
        ex_div_req  = 1'b1;
        ex_op       = DIVU_CONTROL;
        ex_a        = 32'd1234;
        ex_b        = 32'd5;
        @(negedge clk);
        annul_cycle = -1;
        err_cycle   = -1;
        abort_ok    = 1'b1;
        for (int c = 1; c <= int'(TIMEOUT) + 4; c++) begin
            @(posedge clk); #1;
            if (c == int'(TIMEOUT) + 3) ex_div_req = 1'b0;
            @(negedge clk);
            if (div_annul_o && annul_cycle < 0) annul_cycle = c;
            if (err_o && err_cycle < 0) err_cycle = c;
            if (c == int'(TIMEOUT) + 1 || c == int'(TIMEOUT) + 2)
                abort_ok &= stall_o & ~div_start_o & ~div_annul_o;
            if (c >= int'(TIMEOUT) + 3)
                abort_ok &= ~stall_o & ~div_start_o;
        end
        check_eq("wd_annul_cycle", 64'(annul_cycle), 64'(TIMEOUT));
        check_eq("wd_err_cycle", 64'(err_cycle), 64'(TIMEOUT + 1));
        check_eq("wd_err_count", 64'(err_pulses - err_before), 64'd1);
        check_eq("wd_abort", 64'(abort_ok), 64'd1);
        check_eq("wd_no_hilo", 64'(hilo_pulses - hilo_before), 64'd0);
        stub_hang = 1'b0;

        // Reset in the middle of RUN.
        @(posedge clk); #1;
        stub_k     = K_SLOW;
        ex_div_req = 1'b1;
        ex_op      = DIV_CONTROL;
        ex_a       = 32'd77;
        ex_b       = 32'd3;
        repeat (5) @(posedge clk);
        #2;
        check_eq("pre_rst_start", 64'(div_start_o), 64'd1);
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid_run");
        ex_div_req = 1'b0;
        stub_k     = K_NORM;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_div(DIV_CONTROL, 32'd8, 32'd2, 32'd0, 32'd4, LAT_NORM, "div_8_2");
        @(posedge clk); #1;
        ex_div_req = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        check_eq("hilo_total", 64'(hilo_pulses), 64'd6);
        check_eq("err_total", 64'(err_pulses), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
